// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file / writeback definitions.
// Holds the architectural register address width, data width, the number of
// writeback sources and the writeback source enumeration. The enumeration is
// also used by decode and hazard logic to name the writeback sources.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int N_WB_SRC   = 3;

    // Writeback source index; the value is also the base priority (0 = highest).
    typedef enum logic [1:0] {
        WB_LSU = 2'd0,
        WB_CSR = 2'd1,
        WB_ALU = 2'd2
    } wb_src_e;

    // Width of a counter that must hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_age_prio_sel.sv
// wb_age_prio_sel: combinational one-hot grant selection for the writeback port.
// A valid requester whose wait counter has reached MAX_WAIT is promoted above
// all non-promoted requesters; among equals the lowest index wins.
//
// Ports:
//   valid    [N_REQ]          requester valid bits
//   wait_cnt [N_REQ][WAIT_W]  consecutive stalled cycles per requester
//   grant    [N_REQ]          one-hot (or zero) grant, subset of valid
module wb_age_prio_sel
    import rf_pkg::*;
#(
    parameter int N_REQ    = N_WB_SRC,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = cnt_width(MAX_WAIT)
) (
    input  logic [N_REQ-1:0]             valid,
    input  logic [N_REQ-1:0][WAIT_W-1:0] wait_cnt,
    output logic [N_REQ-1:0]             grant
);

    logic [N_REQ-1:0] aged;
    logic [N_REQ-1:0] cand;

    always_comb begin
        aged = '0;
        for (int i = 0; i < N_REQ; i++) begin
            aged[i] = valid[i] && (wait_cnt[i] == WAIT_W'(MAX_WAIT));
        end
    end

    // Promoted requesters form the candidate set whenever any exist; the
    // lowest set bit of the candidate set is then isolated with x & -x.
    always_comb begin
        cand  = (|aged) ? aged : valid;
        grant = cand & (~cand + N_REQ'(1));
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates the single register-file write port between the
// writeback sources (0 = LSU load return, 1 = CSR read, 2 = ALU result).
// Fixed priority with aging-based promotion; one registered write stage drives
// the register file.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   hold          suppresses all grants (trap/flush window)
//   req_valid     per-requester write request
//   req_rd        per-requester destination, slice i = [5i+4:5i]
//   req_wdata     per-requester data, slice i = [32i+31:32i]
//   req_ready     one-hot grant; accept = req_valid & req_ready
//   rf_en         register-file write enable (one cycle after accept)
//   rf_rd         register-file destination
//   rf_wdata      register-file write data
//   conflict_cnt  saturating count of non-hold cycles with >= 2 requesters
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int N_REQ    = N_WB_SRC,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        hold,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*REG_ADDR_W-1:0] req_rd,
    input  logic [N_REQ*XLEN-1:0]       req_wdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        rf_en,
    output logic [REG_ADDR_W-1:0]       rf_rd,
    output logic [XLEN-1:0]             rf_wdata,
    output logic [CNT_W-1:0]            conflict_cnt
);

    localparam int WAIT_W = cnt_width(MAX_WAIT);

    logic [N_REQ-1:0][WAIT_W-1:0] wait_cnt;
    logic [N_REQ-1:0]             grant;
    logic [N_REQ-1:0]             accept;
    logic                         accept_any;
    logic [REG_ADDR_W-1:0]        sel_rd;
    logic [XLEN-1:0]              sel_wdata;
    logic                         conflict;

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        return (v == WAIT_W'(MAX_WAIT)) ? v : v + WAIT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    wb_age_prio_sel #(
        .N_REQ    (N_REQ),
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_sel (
        .valid    (req_valid),
        .wait_cnt (wait_cnt),
        .grant    (grant)
    );

    // Grants are masked during reset so nothing is consumed in a reset cycle.
    assign req_ready  = (rst_n && !hold) ? grant : '0;
    assign accept     = req_valid & req_ready;
    assign accept_any = |accept;
    assign conflict   = ($countones(req_valid) >= 2) && !hold;

    // Accept is one-hot, so OR-ing the masked slices selects the winner.
    always_comb begin
        sel_rd    = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) begin
                sel_rd    = sel_rd    | req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel_wdata = sel_wdata | req_wdata[i*XLEN +: XLEN];
            end
        end
    end

    // Wait counters run through hold windows so held requesters get promoted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] || accept[i]) begin
                    wait_cnt[i] <= '0;
                end else begin
                    wait_cnt[i] <= sat_inc_wait(wait_cnt[i]);
                end
            end
        end
    end

    // ---- accept -> register-file write stage ----
    // Writes to x0 are consumed but never enable the register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_en    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_en <= accept_any && (sel_rd != '0);
            if (accept_any) begin
                rf_rd    <= sel_rd;
                rf_wdata <= sel_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (conflict) begin
            conflict_cnt <= sat_inc_cnt(conflict_cnt);
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios followed by randomized
// traffic, checked against a behavioural model with a scoreboard queue of
// expected register-file writes.
module tb_rf_wb_arbiter;

    localparam int N  = 3;
    localparam int MW = 4;
    localparam int CW = 16;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            hold  = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*5-1:0]  req_rd;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic            rf_en;
    logic [4:0]      rf_rd;
    logic [31:0]     rf_wdata;
    logic [CW-1:0]   conflict_cnt;

    rf_wb_arbiter #(.N_REQ(N), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rf_en        (rf_en),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Requester state owned by the driver.
    bit          pend [N];
    logic [4:0]  p_rd [N];
    logic [31:0] p_wd [N];

    // Accepts predicted by the model at the last sample point.
    logic [N-1:0] acc_mask = '0;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  rd;
        logic [31:0] wd;
    } exp_t;
    exp_t sbq[$];

    // Behavioural model state.
    int          m_wait [N];
    int unsigned m_conf = 0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_wd   = '0;

    // Previous-cycle request snapshot for the requester stability rule.
    logic [N-1:0] prev_v   = '0;
    logic [N-1:0] prev_acc = '0;
    logic [4:0]   prev_rd [N];
    logic [31:0]  prev_wd [N];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- model / checker ----------------
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic [N-1:0] acc;
        int           win;
        int           nvalid;
        exp_rdy = '0;
        win     = -1;
        if (rst_n && !hold) begin
            for (int i = 0; i < N; i++)
                if (win < 0 && req_valid[i] && m_wait[i] == MW) win = i;
            for (int i = 0; i < N; i++)
                if (win < 0 && req_valid[i]) win = i;
            if (win >= 0) exp_rdy[win] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("conflict_cnt", 32'(conflict_cnt), m_conf);
        check("rf_rd", 32'(rf_rd), 32'(m_rd));
        check("rf_wdata", rf_wdata, m_wd);

        for (int i = 0; i < N; i++) begin
            if (prev_v[i] && !prev_acc[i]) begin
                checks++;
                if (!req_valid[i] || req_rd[i*5 +: 5] !== prev_rd[i] ||
                    req_wdata[i*32 +: 32] !== prev_wd[i]) begin
                    errors++;
                    $display("FAIL req_stable[%0d]: valid/payload changed before accept (cycle %0d)", i, cyc);
                end
            end
            prev_rd[i] = req_rd[i*5 +: 5];
            prev_wd[i] = req_wdata[i*32 +: 32];
        end
        prev_v   = req_valid;
        prev_acc = req_valid & req_ready;

        acc = exp_rdy;
        nvalid = 0;
        for (int i = 0; i < N; i++) if (req_valid[i]) nvalid++;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            m_conf = 0;
            m_rd   = '0;
            m_wd   = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) m_wait[i] = 0;
                else if (m_wait[i] < MW) m_wait[i] = m_wait[i] + 1;
            end
            if (nvalid >= 2 && !hold && m_conf < (1 << CW) - 1) m_conf++;
            if (win >= 0) begin
                m_rd = req_rd[win*5 +: 5];
                m_wd = req_wdata[win*32 +: 32];
                if (m_rd != 5'd0) sbq.push_back('{cyc + 1, m_rd, m_wd});
            end
        end
        acc_mask = acc;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            errors++;
            checks++;
            $display("FAIL rf_en_missing: write rd=%0d data=%0h not seen at cycle %0d", e.rd, e.wd, e.cyc);
        end
        if (rf_en === 1'b1) begin
            if (sbq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL rf_en_spurious: got rf_en=1 rd=%0d expected no write (cycle %0d)", rf_rd, cyc);
            end else begin
                e = sbq.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_rd", 32'(rf_rd), 32'(e.rd));
                check("wr_data", rf_wdata, e.wd);
            end
        end else if (rf_en !== 1'b0) begin
            check("rf_en_known", 32'(rf_en), 32'd0);
        end
    end

    // ---------------- driver ----------------
    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_rd[i*5 +: 5]      = p_rd[i];
            req_wdata[i*32 +: 32] = p_wd[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc_mask[i]) pend[i] = 1'b0;
        apply();
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] wd);
        pend[i] = 1'b1;
        p_rd[i] = rd;
        p_wd[i] = wd;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((pend[0] || pend[1] || pend[2]) && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (pend[0] || pend[1] || pend[2]) begin
            errors++;
            $display("FAIL drain_timeout: got pending=%b expected 000 after %0d cycles", {pend[2], pend[1], pend[0]}, max_cycles);
            for (int i = 0; i < N; i++) pend[i] = 1'b0;
            apply();
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            p_rd[i] = '0;
            p_wd[i] = '0;
        end
        apply();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // single request from the ALU
        set_req(2, 5'd5, 32'hDEADBEEF);
        apply();
        wait_idle(10);
        repeat (2) step();

        // three-way contention
        set_req(0, 5'd1, 32'h1111_0000);
        set_req(1, 5'd2, 32'h2222_0000);
        set_req(2, 5'd3, 32'h3333_0000);
        apply();
        wait_idle(10);
        step();

        // aging: LSU keeps re-requesting, ALU must still get through
        set_req(2, 5'd9, 32'hA11A_0009);
        for (int k = 0; k < 8; k++) begin
            if (!pend[0]) set_req(0, 5'(10 + k), 32'hB0B0_0000 + k);
            apply();
            step();
        end
        wait_idle(10);
        step();

        // write to x0 is consumed without enabling the register file
        set_req(1, 5'd0, 32'h0000_1234);
        apply();
        wait_idle(10);
        step();

        // hold window: counters saturate, ALU wins on release
        hold = 1'b1;
        set_req(2, 5'd12, 32'hC0DE_0012);
        apply();
        repeat (6) step();
        hold = 1'b0;
        set_req(0, 5'd13, 32'hC0DE_0013);
        apply();
        wait_idle(10);
        step();

        // reset while a request is pending
        set_req(0, 5'd7, 32'h7777_7777);
        rst_n = 1'b0;
        apply();
        repeat (2) step();
        rst_n = 1'b1;
        wait_idle(10);
        step();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            hold  = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 5'($urandom_range(0, 31)), $urandom);
            apply();
            step();
        end

        hold  = 1'b0;
        rst_n = 1'b1;
        apply();
        wait_idle(50);
        repeat (3) step();
        check("scoreboard_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Arbitrates the single register-file write port between several writeback sources: index 0 = LSU load return, 1 = CSR read result, 2 = ALU result. Fixed priority with aging-based promotion, so no source starves. Drives the register file's rf_en/rd/wdata inputs through one output register stage. Sits between the execute/memory/CSR units and reg_file.

Parameters:
N_REQ, 3, number of writeback requesters; index 0 has highest base priority
MAX_WAIT, 4, consecutive stalled cycles after which a requester is promoted
CNT_W, 16, width of the conflict performance counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
hold  input  1  when 1, no grants are issued (trap/flush window)
req_valid  input  N_REQ  per-requester write request
req_rd  input  N_REQ*5  per-requester destination register, slice i = [5i+4:5i]
req_wdata  input  N_REQ*32  per-requester write data, slice i = [32i+31:32i]
req_ready  output  N_REQ  one-hot grant; accept occurs when valid[i] & ready[i]
rf_en  output  1  register-file write enable
rf_rd  output  5  register-file destination
rf_wdata  output  32  register-file write data
conflict_cnt  output  CNT_W  saturating count of cycles with two or more valid requesters

Behaviour:
- Reset (rst_n = 0 at a clock edge): rf_en = 0, rf_rd = 0, rf_wdata = 0, conflict_cnt = 0, all wait counters = 0. req_ready is forced to 0 while rst_n = 0.
- Reset mid-operation: a write accepted in the same cycle that reset is sampled is dropped; rf_en stays 0 in the following cycle.
- Requester rule: once valid[i] is asserted, the requester keeps valid and its payload stable until accepted. Bench checks this as an assertion.
- Grant (combinational, same cycle):
  - If hold = 1: req_ready = 0.
  - Otherwise, if any valid requester has wait_cnt = MAX_WAIT, the lowest-index such requester wins.
  - Otherwise, the lowest-index valid requester wins.
  - At most one ready bit is set.
  - req_ready[i] never asserts without valid[i].
- Wait counters: wait_cnt[i] is 3 bits wide, or clog2(MAX_WAIT+1) bits in general. Each cycle:
  - clears to 0 if valid[i] = 0 or requester i is accepted;
  - otherwise increments, saturating at MAX_WAIT.
  - Counters keep counting while hold = 1.
- Write stage (latency 1): on an accept at cycle t, the next edge loads rf_rd = req_rd[i] and rf_wdata = req_wdata[i].
  - rf_en = 1 for exactly cycle t+1 if req_rd[i] != 0.
  - If req_rd[i] = 0, the request is still accepted and consumed, but rf_en = 0.
  - With no accept, rf_en = 0 next cycle; rf_rd and rf_wdata hold their last value.
- Back-to-back: accepts in consecutive cycles produce rf_en high in consecutive cycles. Throughput is 1 write per cycle.
- conflict_cnt: increments when popcount(req_valid) >= 2 and hold = 0, saturating at all-ones.
- Simultaneous promotion: if several requesters are at MAX_WAIT together, base priority (lowest index) breaks the tie.

Decomposition:
- Shared package rf_pkg holds:
  - constants REG_ADDR_W = 5, XLEN = 32, N_WB_SRC = 3;
  - enum wb_src_e {WB_LSU = 0, WB_CSR = 1, WB_ALU = 2}, also reused by the decode/hazard logic.
- One natural sub-module: wb_age_prio_sel. It takes valid and the wait counters and returns the one-hot grant, and is purely combinational. The top level contains the wait counters, write register and conflict counter.

Test Plan:
- Single request: valid[2] = 1, rd = 5, wdata = 0xDEADBEEF at cycle t → ready[2] = 1 at t; at t+1 rf_en = 1, rf_rd = 5, rf_wdata = 0xDEADBEEF; at t+2 rf_en = 0.
- Contention: valid = 3'b111 held, each requester dropping valid after its accept → grant order 0, 1, 2 on three consecutive cycles; rf_en high for 3 cycles; conflict_cnt = 2.
- Aging: requester 0 valid for 8 cycles with new payloads each accept, requester 2 valid continuously, MAX_WAIT = 4 → requester 2 is granted on its 5th cycle of waiting (wait_cnt = 4), even though requester 0 is valid.
- x0 write: valid[1] = 1, rd = 0, wdata = 0x1234 → ready[1] = 1; next cycle rf_en = 0.
- Hold: hold = 1 for 6 cycles with valid[2] = 1 → ready = 0 throughout and wait_cnt[2] saturates at 4. Once hold = 0, requester 2 is granted immediately, even with valid[0] also asserted.
- Reset mid-operation: accept requester 0 with rd = 7 in the same cycle rst_n = 0 → next cycle rf_en = 0, rf_rd = 0, conflict_cnt = 0, req_ready = 0 while reset is held.
